// File: rtl/adxl345_spi_responder_if.sv
// Four-wire SPI link between the master controller and the ADXL345 responder model.
// The master drives csn/sclk/sdi. The responder drives sdo and its output enable.
interface adxl345_spi_responder_if;
    logic spi_csn;
    logic spi_sclk;
    logic spi_sdi;
    logic spi_sdo;
    logic spi_sdo_oe;

    modport master (
        output spi_csn,
        output spi_sclk,
        output spi_sdi,
        input  spi_sdo,
        input  spi_sdo_oe
    );

    modport slave (
        input  spi_csn,
        input  spi_sclk,
        input  spi_sdi,
        output spi_sdo,
        output spi_sdo_oe
    );
endinterface

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 responder that emulates the ADXL345 register map.
// X/Y/Z samples come from fabric logic. Everything runs on clk, with SPI inputs oversampled.
module adxl345_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic                          clk,
    input  logic                          reset,
    adxl345_spi_responder_if.slave        spi,
    input  logic [15:0]                   data_x,
    input  logic [15:0]                   data_y,
    input  logic [15:0]                   data_z,
    output logic [7:0]                    bw_rate,
    output logic [7:0]                    power_ctl,
    output logic [7:0]                    int_enable,
    output logic [7:0]                    data_format,
    output logic                          measure_en,
    output logic                          wr_strobe,
    output logic [5:0]                    wr_addr,
    output logic [7:0]                    wr_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    localparam logic [5:0] A_DEVID       = 6'h00;
    localparam logic [5:0] A_BW_RATE     = 6'h2C;
    localparam logic [5:0] A_POWER_CTL   = 6'h2D;
    localparam logic [5:0] A_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] A_DATA_FORMAT = 6'h31;
    localparam logic [5:0] A_DATAX0      = 6'h32;
    localparam logic [5:0] A_DATAX1      = 6'h33;
    localparam logic [5:0] A_DATAY0      = 6'h34;
    localparam logic [5:0] A_DATAY1      = 6'h35;
    localparam logic [5:0] A_DATAZ0      = 6'h36;
    localparam logic [5:0] A_DATAZ1      = 6'h37;

    logic r_csn_meta, r_csn_sync, r_csn_prev;
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_sdi_meta, r_sdi_sync;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic        r_rw;
    logic        r_mb;
    logic        r_first;
    logic [5:0]  r_addr;
    logic        r_sdo;
    logic        r_sdo_oe;
    logic [15:0] r_shadow_x, r_shadow_y, r_shadow_z;
    logic [7:0]  r_bw_rate, r_power_ctl, r_int_enable, r_data_format;
    logic        r_wr_strobe;
    logic [5:0]  r_wr_addr;
    logic [7:0]  r_wr_data;

    logic       w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;
    logic [7:0] w_rx_byte;
    logic [5:0] w_next_addr;

    // CSN chain resets asserted: a transfer caught by reset must see CSN high before restarting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csn_meta  <= 1'b0;
            r_csn_sync  <= 1'b0;
            r_csn_prev  <= 1'b0;
            r_sclk_meta <= 1'b1;
            r_sclk_sync <= 1'b1;
            r_sclk_prev <= 1'b1;
            r_sdi_meta  <= 1'b0;
            r_sdi_sync  <= 1'b0;
        end else begin
            r_csn_meta  <= spi.spi_csn;
            r_csn_sync  <= r_csn_meta;
            r_csn_prev  <= r_csn_sync;
            r_sclk_meta <= spi.spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_sdi_meta  <= spi.spi_sdi;
            r_sdi_sync  <= r_sdi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_csn_fall  = ~r_csn_sync & r_csn_prev;
    assign w_csn_rise  = r_csn_sync & ~r_csn_prev;
    assign w_rx_byte   = {r_rx_shift, r_sdi_sync};
    assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;

    function automatic logic [7:0] f_reg_read(input logic [5:0] a);
        case (a)
            A_DEVID:       return DEVID;
            A_BW_RATE:     return r_bw_rate;
            A_POWER_CTL:   return r_power_ctl;
            A_INT_ENABLE:  return r_int_enable;
            A_DATA_FORMAT: return r_data_format;
            A_DATAX0:      return r_shadow_x[7:0];
            A_DATAX1:      return r_shadow_x[15:8];
            A_DATAY0:      return r_shadow_y[7:0];
            A_DATAY1:      return r_shadow_y[15:8];
            A_DATAZ0:      return r_shadow_z[7:0];
            A_DATAZ1:      return r_shadow_z[15:8];
            default:       return 8'h00;
        endcase
    endfunction

    function automatic logic f_writable(input logic [5:0] a);
        return (a == A_BW_RATE) || (a == A_POWER_CTL) ||
               (a == A_INT_ENABLE) || (a == A_DATA_FORMAT);
    endfunction

    // NOTE: every register here uses <= so all branches see the pre-edge values of r_addr, r_tx_shift, etc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 7'd0;
            r_tx_shift    <= 8'd0;
            r_rw          <= 1'b0;
            r_mb          <= 1'b0;
            r_first       <= 1'b0;
            r_addr        <= 6'd0;
            r_sdo         <= 1'b0;
            r_sdo_oe      <= 1'b0;
            r_shadow_x    <= 16'd0;
            r_shadow_y    <= 16'd0;
            r_shadow_z    <= 16'd0;
            r_bw_rate     <= BW_RATE_RST;
            r_power_ctl   <= 8'd0;
            r_int_enable  <= 8'd0;
            r_data_format <= 8'd0;
            r_wr_strobe   <= 1'b0;
            r_wr_addr     <= 6'd0;
            r_wr_data     <= 8'd0;
        end else begin
            r_wr_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sdo    <= 1'b0;
                    r_sdo_oe <= 1'b0;
                    if (w_csn_fall) begin
                        r_shadow_x <= data_x;
                        r_shadow_y <= data_y;
                        r_shadow_z <= data_z;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (w_csn_rise) begin
                        r_state   <= ST_IDLE;
                        r_sdo     <= 1'b0;
                        r_sdo_oe  <= 1'b0;
                        r_bit_cnt <= 3'd0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_byte[6:0];
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rw       <= w_rx_byte[7];
                            r_mb       <= w_rx_byte[6];
                            r_addr     <= w_rx_byte[5:0];
                            r_first    <= 1'b1;
                            r_sdo_oe   <= 1'b1;
                            r_tx_shift <= w_rx_byte[7] ? f_reg_read(w_rx_byte[5:0]) : 8'h00;
                            r_state    <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_csn_rise) begin
                        r_state   <= ST_IDLE;
                        r_sdo     <= 1'b0;
                        r_sdo_oe  <= 1'b0;
                        r_bit_cnt <= 3'd0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_byte[6:0];
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            // Without MB only the first data byte of a write may commit.
                            if (!r_rw && (r_mb || r_first) && f_writable(r_addr)) begin
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_addr;
                                r_wr_data   <= w_rx_byte;
                                case (r_addr)
                                    A_BW_RATE:     r_bw_rate     <= w_rx_byte;
                                    A_POWER_CTL:   r_power_ctl   <= w_rx_byte;
                                    A_INT_ENABLE:  r_int_enable  <= w_rx_byte;
                                    A_DATA_FORMAT: r_data_format <= w_rx_byte;
                                    default:       ;
                                endcase
                            end
                            r_first <= 1'b0;
                            r_addr  <= w_next_addr;
                            if (r_rw) begin
                                r_tx_shift <= f_reg_read(w_next_addr);
                            end
                        end
                    end else if (w_sclk_fall) begin
                        r_sdo      <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi.spi_sdo    = r_sdo;
    assign spi.spi_sdo_oe = r_sdo_oe;
    assign bw_rate        = r_bw_rate;
    assign power_ctl      = r_power_ctl;
    assign int_enable     = r_int_enable;
    assign data_format    = r_data_format;
    assign measure_en     = r_power_ctl[3];
    assign wr_strobe      = r_wr_strobe;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Bench for the ADXL345 responder: a mode-3 master drives the link.
// A register-map model predicts every byte and every committed write.
module tb_adxl345_spi_responder;

    localparam int HALF = 60;

    logic        clk;
    logic        reset;
    logic [15:0] data_x, data_y, data_z;
    logic [7:0]  bw_rate, power_ctl, int_enable, data_format;
    logic        measure_en, wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    adxl345_spi_responder_if bus ();

    adxl345_spi_responder dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (bus.slave),
        .data_x      (data_x),
        .data_y      (data_y),
        .data_z      (data_z),
        .bw_rate     (bw_rate),
        .power_ctl   (power_ctl),
        .int_enable  (int_enable),
        .data_format (data_format),
        .measure_en  (measure_en),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    // Reference register map.
    logic [7:0]  m_bw, m_pwr, m_ie, m_fmt;
    logic [15:0] m_sx, m_sy, m_sz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every clk cycle in which wr_strobe is high, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (!reset && wr_strobe === 1'b1) strobe_cnt++;
    end

    function automatic logic [7:0] model_read(input logic [5:0] a);
        case (a)
            6'h00:   return 8'hE5;
            6'h2C:   return m_bw;
            6'h2D:   return m_pwr;
            6'h2E:   return m_ie;
            6'h31:   return m_fmt;
            6'h32:   return m_sx[7:0];
            6'h33:   return m_sx[15:8];
            6'h34:   return m_sy[7:0];
            6'h35:   return m_sy[15:8];
            6'h36:   return m_sz[7:0];
            6'h37:   return m_sz[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic model_writable(input logic [5:0] a);
        return (a == 6'h2C) || (a == 6'h2D) || (a == 6'h2E) || (a == 6'h31);
    endfunction

    task automatic model_reset();
        m_bw = 8'h0A; m_pwr = 8'h00; m_ie = 8'h00; m_fmt = 8'h00;
        m_sx = 16'h0; m_sy = 16'h0; m_sz = 16'h0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [7:0] d);
        case (a)
            6'h2C: m_bw  = d;
            6'h2D: m_pwr = d;
            6'h2E: m_ie  = d;
            6'h31: m_fmt = d;
            default: ;
        endcase
    endtask

    task automatic begin_xfer();
        m_sx = data_x; m_sy = data_y; m_sz = data_z;
        bus.spi_csn = 1'b0;
        #HALF;
    endtask

    task automatic end_xfer();
        bus.spi_csn = 1'b1;
        #(4 * HALF);
    endtask

    // Master shifts sdi on the falling edge and samples sdo just before the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                            output logic oe_all, output logic oe_any);
        rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_sclk = 1'b0;
            bus.spi_sdi  = tx[i];
            #HALF;
            rx[i]  = bus.spi_sdo;
            oe_all = oe_all & bus.spi_sdo_oe;
            oe_any = oe_any | bus.spi_sdo_oe;
            bus.spi_sclk = 1'b1;
            #HALF;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic a, b;
        spi_bits(tx, 8, rx, a, b);
    endtask

    task automatic check_regs(input string tag);
        checks++; if (bw_rate !== m_bw) begin errors++; $display("FAIL %s bw_rate: got %h expected %h", tag, bw_rate, m_bw); end
        checks++; if (power_ctl !== m_pwr) begin errors++; $display("FAIL %s power_ctl: got %h expected %h", tag, power_ctl, m_pwr); end
        checks++; if (int_enable !== m_ie) begin errors++; $display("FAIL %s int_enable: got %h expected %h", tag, int_enable, m_ie); end
        checks++; if (data_format !== m_fmt) begin errors++; $display("FAIL %s data_format: got %h expected %h", tag, data_format, m_fmt); end
        checks++; if (measure_en !== m_pwr[3]) begin errors++; $display("FAIL %s measure_en: got %b expected %b", tag, measure_en, m_pwr[3]); end
    endtask

    task automatic devid_read(input string tag);
        logic [7:0] rx, dummy;
        logic oe_all, oe_any;
        begin_xfer();
        spi_bits(8'h80, 8, dummy, oe_all, oe_any);
        checks++; if (oe_any !== 1'b0) begin errors++; $display("FAIL %s oe_during_cmd: got %b expected 0", tag, oe_any); end
        spi_bits(8'h00, 8, rx, oe_all, oe_any);
        checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL %s oe_during_data: got %b expected 1", tag, oe_all); end
        checks++; if (rx !== 8'hE5) begin errors++; $display("FAIL %s devid: got %h expected e5", tag, rx); end
        end_xfer();
        checks++; if (bus.spi_sdo_oe !== 1'b0) begin errors++; $display("FAIL %s oe_after_csn: got %b expected 0", tag, bus.spi_sdo_oe); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (bus.spi_sdo_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", bus.spi_sdo_oe); end
        checks++; if (bus.spi_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", bus.spi_sdo); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        checks++; if (wr_addr !== 6'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        model_reset();
        check_regs("reset");
        #40;
        reset = 1'b0;
        #100;
    endtask

    task automatic test_devid();
        devid_read("devid");
    endtask

    task automatic test_write_power_ctl();
        logic [7:0] rx;
        int s0;
        s0 = strobe_cnt;
        begin_xfer();
        spi_byte(8'h2D, rx);
        spi_byte(8'h08, rx);
        end_xfer();
        model_write(6'h2D, 8'h08);
        check_regs("wr_pwr");
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL wr_pwr strobes: got %0d expected 1", strobe_cnt - s0); end
        checks++; if (wr_addr !== 6'h2D) begin errors++; $display("FAIL wr_pwr wr_addr: got %h expected 2d", wr_addr); end
        checks++; if (wr_data !== 8'h08) begin errors++; $display("FAIL wr_pwr wr_data: got %h expected 08", wr_data); end
    endtask

    task automatic test_burst_read();
        logic [7:0] rx, exp_b;
        data_x = 16'h1234; data_y = 16'hFF9C; data_z = 16'h00FA;
        #20;
        begin_xfer();
        spi_byte(8'hF2, rx);
        for (int i = 0; i < 6; i++) begin
            spi_byte(8'h00, rx);
            exp_b = model_read(6'(6'h32 + i));
            checks++; if (rx !== exp_b) begin errors++; $display("FAIL burst byte%0d: got %h expected %h", i, rx, exp_b); end
            if (i == 0) data_x = 16'h5555;
        end
        end_xfer();
    endtask

    task automatic test_readonly_write();
        logic [7:0] rx;
        int s0;
        s0 = strobe_cnt;
        begin_xfer();
        spi_byte(8'h00, rx);
        spi_byte(8'h11, rx);
        end_xfer();
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL ro_write strobes: got %0d expected 0", strobe_cnt - s0); end
        devid_read("ro_write");
    endtask

    task automatic test_aborted_write();
        logic [7:0] rx;
        logic a, b;
        int s0;
        s0 = strobe_cnt;
        begin_xfer();
        spi_byte(8'h31, rx);
        spi_bits(8'hAB, 5, rx, a, b);
        end_xfer();
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL abort strobes: got %0d expected 0", strobe_cnt - s0); end
        check_regs("abort");
        begin_xfer();
        spi_byte(8'h31, rx);
        spi_byte(8'h0B, rx);
        end_xfer();
        model_write(6'h31, 8'h0B);
        check_regs("after_abort");
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL after_abort strobes: got %0d expected 1", strobe_cnt - s0); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] rx;
        begin_xfer();
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap byte0: got %h expected 00", rx); end
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'hE5) begin errors++; $display("FAIL wrap byte1: got %h expected e5", rx); end
        end_xfer();
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] rx;
        logic a, b;
        begin_xfer();
        spi_byte(8'hF2, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 3, rx, a, b);
        reset = 1'b1;
        #2;
        checks++; if (bus.spi_sdo_oe !== 1'b0) begin errors++; $display("FAIL midrst oe: got %b expected 0", bus.spi_sdo_oe); end
        model_reset();
        check_regs("midrst");
        #30;
        reset = 1'b0;
        spi_bits(8'h00, 5, rx, a, b);
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL midrst oe_after_release: got %b expected 0", b); end
        spi_byte(8'h00, rx);
        end_xfer();
        devid_read("midrst");
    endtask

    task automatic test_random();
        logic [5:0] wlist [6];
        logic [7:0] rx, tx, exp_b, last_d;
        logic [5:0] cur, last_a;
        logic rw, mb, any_wr;
        int nbytes, s0, exp_strobes;
        wlist[0] = 6'h2C; wlist[1] = 6'h2D; wlist[2] = 6'h2E;
        wlist[3] = 6'h31; wlist[4] = 6'h32; wlist[5] = 6'h00;
        for (int t = 0; t < 30; t++) begin
            rw     = 1'($urandom_range(0, 1));
            mb     = 1'($urandom_range(0, 1));
            cur    = ($urandom_range(0, 1) == 1) ? wlist[$urandom_range(0, 5)] : 6'($urandom);
            nbytes = $urandom_range(1, 4);
            data_x = 16'($urandom); data_y = 16'($urandom); data_z = 16'($urandom);
            s0 = strobe_cnt; exp_strobes = 0; any_wr = 1'b0;
            last_a = 6'h0; last_d = 8'h0;
            #20;
            begin_xfer();
            spi_byte({rw, mb, cur}, rx);
            for (int i = 0; i < nbytes; i++) begin
                tx = 8'($urandom);
                if (rw) begin
                    exp_b = model_read(cur);
                    spi_byte(tx, rx);
                    checks++; if (rx !== exp_b) begin errors++; $display("FAIL rand t%0d read a=%h: got %h expected %h", t, cur, rx, exp_b); end
                end else begin
                    spi_byte(tx, rx);
                    if (model_writable(cur) && (mb || i == 0)) begin
                        model_write(cur, tx);
                        exp_strobes++; any_wr = 1'b1; last_a = cur; last_d = tx;
                    end
                end
                if (mb) cur = cur + 6'd1;
            end
            end_xfer();
            check_regs("rand");
            checks++; if (strobe_cnt - s0 !== exp_strobes) begin errors++; $display("FAIL rand t%0d strobes: got %0d expected %0d", t, strobe_cnt - s0, exp_strobes); end
            if (any_wr) begin
                checks++; if (wr_addr !== last_a || wr_data !== last_d) begin errors++; $display("FAIL rand t%0d last_wr: got %h/%h expected %h/%h", t, wr_addr, wr_data, last_a, last_d); end
            end
        end
    endtask

    initial begin
        // NOTE: bench-side stimulus uses blocking assignments; only the DUT's clocked state uses <=.
        bus.spi_csn  = 1'b1;
        bus.spi_sclk = 1'b1;
        bus.spi_sdi  = 1'b0;
        data_x = 16'h0; data_y = 16'h0; data_z = 16'h0;
        reset = 1'b0;
        #3;
        test_reset();
        test_devid();
        test_write_power_ctl();
        test_burst_read();
        test_readonly_write();
        test_aborted_write();
        test_addr_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adxl345_spi_responder.md
Name: adxl345_spi_responder

Overview: SPI-slave model of the ADXL345 G-sensor. It is the responder end of the 4-wire, mode-3 link driven by the team's SPI master controller. It serves the accelerometer register map from parallel X/Y/Z samples supplied by fabric logic. It is used in bench loopback and board-to-board tests, so the master and display path run without the physical sensor.

Parameters:
DEVID, 8'hE5, value returned at register 0x00.
BW_RATE_RST, 8'h0A, reset value of register 0x2C.

Ports:
clk  input  1  system clock; must be at least 8x the SCLK frequency.
reset  input  1  asynchronous, active-high reset.
spi_csn  input  1  chip select from master, active low.
spi_sclk  input  1  SPI clock from master (CPOL=1, CPHA=1).
spi_sdi  input  1  master-out data.
spi_sdo  output  1  slave-out data.
spi_sdo_oe  output  1  output enable for spi_sdo; the top level builds the tri-state.
data_x  input  16  signed X sample, two's complement.
data_y  input  16  signed Y sample, two's complement.
data_z  input  16  signed Z sample, two's complement.
bw_rate  output  8  register 0x2C.
power_ctl  output  8  register 0x2D.
int_enable  output  8  register 0x2E.
data_format  output  8  register 0x31.
measure_en  output  1  power_ctl[3].
wr_strobe  output  1  one-cycle pulse on a committed write.
wr_addr  output  6  address of the last committed write.
wr_data  output  8  data of the last committed write.

Behaviour:
- Input sync: spi_csn, spi_sclk and spi_sdi pass through 2-flop synchronisers. Edges are detected on the synchronised SCLK and CSN. All logic runs on clk.
- Reset (async):
  - State goes to IDLE; spi_sdo=0 and spi_sdo_oe=0.
  - bw_rate=BW_RATE_RST; power_ctl, int_enable and data_format are 0.
  - wr_strobe=0, wr_addr=0, wr_data=0; shadow samples are 0.
- FSM states: IDLE, CMD, DATA.
- IDLE -> CMD on a synchronised CSN falling edge:
  - data_x/y/z are copied into shadow registers in the same cycle. A burst therefore returns one coherent sample set.
  - bit_cnt is cleared to 0.
- Bit timing: sdi is sampled MSB first on each synchronised SCLK rising edge. The slave changes sdo on each synchronised SCLK falling edge.
- CMD: after the 8th rising edge, the FSM latches rw=bit7, mb=bit6 and addr=bits5:0, then enters DATA.
  - On a read, tx_shift is loaded with reg[addr] in that cycle.
  - spi_sdo_oe rises in that cycle.
- DATA, read: on each falling edge, spi_sdo <= tx_shift[7] and tx_shift shifts left. The first falling edge after the command therefore presents data bit 7.
- Byte boundary (8th rising edge in DATA):
  - Write: rx byte is committed if addr is writable (0x2C, 0x2D, 0x2E, 0x31). wr_strobe pulses for 1 cycle with wr_addr/wr_data. Writes to any other address are discarded with no strobe.
  - mb=1: addr <= addr+1 modulo 64 (0x3F wraps to 0x00). On a read, tx_shift reloads from the new address.
  - mb=0: addr holds. Further read bytes repeat the same register; further write bytes are discarded.
- Register map (read):
  - 0x00 = DEVID.
  - 0x2C, 0x2D, 0x2E, 0x31 = stored values.
  - 0x32/0x33 = shadow_x[7:0] / [15:8].
  - 0x34/0x35 = shadow_y low/high.
  - 0x36/0x37 = shadow_z low/high.
  - All other addresses read 0x00.
- CSN rising (any state): return to IDLE in the next cycle. spi_sdo_oe=0 and spi_sdo=0. A partial byte is discarded and no write occurs. bit_cnt is cleared.
- CSN low with no SCLK: state holds indefinitely.
- Reset asserted mid-transfer: immediate return to reset values. The transfer restarts only after CSN goes high, then low again.
- Latency: wr_strobe and register update occur 3 clk cycles after the raw SCLK rising edge that carries the last write bit.

Test Plan:
- DEVID read: CSN low, cmd 0x80, 8 dummy clocks -> master samples 0xE5; spi_sdo_oe high only during the data byte.
- Write power_ctl: cmd 0x2D, data 0x08 -> power_ctl=0x08, measure_en=1; one wr_strobe with wr_addr=0x2D, wr_data=0x08.
- Burst read:
  - Setup: data_x=0x1234, data_y=0xFF9C, data_z=0x00FA; cmd 0xF2, 6 bytes.
  - Expect: 34 12 9C FF FA 00.
  - Changing data_x to 0x5555 after byte 1 still returns 12 as byte 2.
- Read-only write: cmd 0x00, data 0x11 -> no wr_strobe; a subsequent DEVID read is still 0xE5.
- Aborted write: cmd 0x31, 5 data bits, then CSN high -> data_format stays 0x00, no strobe; the next full transaction works normally.
- Address wrap: MB read cmd 0xFF, 2 bytes -> 0x00 then 0xE5.
- Reset mid-burst: assert reset during byte 2 of a 0xF2 read -> spi_sdo_oe=0 immediately and registers reset; after a CSN cycle, a DEVID read returns 0xE5.
